// File: rtl/h_qperm_seq.sv
// ---------------------------------------------------------------------------
// h_qperm_seq
// Iterative Twofish h-function q-permutation sequencer. It produces the
// pre-MDS h result. One q0 box and one q1 box are shared across all four
// byte lanes and all k+1 stages. Each RUN cycle pushes one byte through q0
// and one byte through q1. A stage therefore takes two cycles (sub 0, sub 1).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake; x, klen, l0..l3 sampled on accept
//   klen              0->k=2, 1->k=3, 2/3->k=4 (clamped to MAX_K)
//   out_valid/out_ready result handshake; y held stable while out_valid
//   y                 pre-MDS h result, byte n = y[8n+7:8n]
//   busy              high while the permutation chain is running
//   dbg_state         current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE. out_valid is high only in
// DONE, and y does not change until the transfer completes.
// ---------------------------------------------------------------------------
module h_qperm_seq #(
    parameter int MAX_K = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  klen,
    input  logic [31:0] x,
    input  logic [31:0] l0,
    input  logic [31:0] l1,
    input  logic [31:0] l2,
    input  logic [31:0] l3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Stages in execution order; k selects the entry point.
    typedef enum logic [2:0] {
        STG_S4 = 3'd0,
        STG_S3 = 3'd1,
        STG_SI = 3'd2,
        STG_SM = 3'd3,
        STG_SO = 3'd4
    } stage_t;

    localparam logic [2:0] MAX_K_L = 3'(MAX_K);

    // 4-bit tables that define q0 and q1.
    localparam logic [3:0] Q0_T0 [16] = '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2,
                                          4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4};
    localparam logic [3:0] Q0_T1 [16] = '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5,
                                          4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD};
    localparam logic [3:0] Q0_T2 [16] = '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0,
                                          4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1};
    localparam logic [3:0] Q0_T3 [16] = '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE,
                                          4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA};
    localparam logic [3:0] Q1_T0 [16] = '{4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE,
                                          4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5};
    localparam logic [3:0] Q1_T1 [16] = '{4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7,
                                          4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8};
    localparam logic [3:0] Q1_T2 [16] = '{4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA,
                                          4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF};
    localparam logic [3:0] Q1_T3 [16] = '{4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE,
                                          4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA};

    // Combinational q permutation; use_q1 selects the q1 tables.
    function automatic logic [7:0] q_box(input logic [7:0] v, input logic use_q1);
        logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
        a0 = v[7:4];
        b0 = v[3:0];
        a1 = a0 ^ b0;
        b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
        a2 = use_q1 ? Q1_T0[a1] : Q0_T0[a1];
        b2 = use_q1 ? Q1_T1[b1] : Q0_T1[b1];
        a3 = a2 ^ b2;
        b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
        a4 = use_q1 ? Q1_T2[a3] : Q0_T2[a3];
        b4 = use_q1 ? Q1_T3[b3] : Q0_T3[b3];
        return {b4, a4};
    endfunction

    state_t            state_q, state_d;
    stage_t            stage_q, stage_d;
    logic              sub_q, sub_d;
    logic [3:0][7:0]   byte_q, byte_d;
    logic [3:0][31:0]  key_q, key_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [2:0]        k_req, k_eff;
    stage_t            first_stage;
    logic [1:0]        q0_sel, q1_sel;
    logic [3:0][7:0]   stage_key;
    logic [7:0]        q0_new, q1_new;

    // Effective key-word count and the stage the chain starts from.
    always_comb begin
        case (klen)
            2'd0:    k_req = 3'd2;
            2'd1:    k_req = 3'd3;
            default: k_req = 3'd4;
        endcase
        k_eff = (k_req > MAX_K_L) ? MAX_K_L : k_req;
        case (k_eff)
            3'd4:    first_stage = STG_S4;
            3'd3:    first_stage = STG_S3;
            default: first_stage = STG_SI;
        endcase
    end

    // Byte-to-box routing for the current (stage, sub) and the stage key.
    always_comb begin
        q0_sel    = 2'd0;
        q1_sel    = 2'd0;
        stage_key = '0;
        case (stage_q)
            STG_S4: begin
                stage_key = key_q[3];
                q1_sel    = sub_q ? 2'd3 : 2'd0;
                q0_sel    = sub_q ? 2'd2 : 2'd1;
            end
            STG_S3: begin
                stage_key = key_q[2];
                q1_sel    = sub_q ? 2'd1 : 2'd0;
                q0_sel    = sub_q ? 2'd3 : 2'd2;
            end
            STG_SI: begin
                stage_key = key_q[1];
                q0_sel    = sub_q ? 2'd2 : 2'd0;
                q1_sel    = sub_q ? 2'd3 : 2'd1;
            end
            STG_SM: begin
                stage_key = key_q[0];
                q0_sel    = sub_q ? 2'd1 : 2'd0;
                q1_sel    = sub_q ? 2'd3 : 2'd2;
            end
            STG_SO: begin
                // Output stage has no key whitening.
                stage_key = '0;
                q1_sel    = sub_q ? 2'd2 : 2'd0;
                q0_sel    = sub_q ? 2'd3 : 2'd1;
            end
            default: begin
                stage_key = '0;
            end
        endcase
        q0_new = q_box(byte_q[q0_sel], 1'b0) ^ stage_key[q0_sel];
        q1_new = q_box(byte_q[q1_sel], 1'b1) ^ stage_key[q1_sel];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        sub_d   = sub_q;
        byte_d  = byte_q;
        key_d   = key_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    byte_d  = x;
                    key_d   = {l3, l2, l1, l0};
                    stage_d = first_stage;
                    sub_d   = 1'b0;
                end
            end
            ST_RUN: begin
                // The two selects never collide, so both lanes update in place.
                byte_d[q0_sel] = q0_new;
                byte_d[q1_sel] = q1_new;
                sub_d          = ~sub_q;
                if (sub_q) begin
                    if (stage_q == STG_SO) begin
                        state_d = ST_DONE;
                    end else begin
                        stage_d = stage_t'(stage_q + 3'd1);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stage_q     <= STG_S4;
            sub_q       <= 1'b0;
            byte_q      <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            sub_q       <= sub_d;
            byte_q      <= byte_d;
            key_q       <= key_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y         = byte_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_h_qperm_seq.sv
// Testbench for h_qperm_seq: scoreboard of expected h results and latencies,
// checked when the DUT presents a result.
module tb_h_qperm_seq;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  klen;
    logic [31:0] x, l0, l1, l2, l3;
    logic        out_valid, out_ready;
    logic [31:0] y;
    logic        busy;
    logic [1:0]  dbg_state;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [31:0] y2;
    logic [1:0]  dbg_state2;

    h_qperm_seq #(.MAX_K(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .klen(klen),
        .x(x), .l0(l0), .l1(l1), .l2(l2), .l3(l3), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .busy(busy), .dbg_state(dbg_state)
    );

    h_qperm_seq #(.MAX_K(2)) dut_k2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .klen(klen),
        .x(x), .l0(l0), .l1(l1), .l2(l2), .l3(l3), .out_valid(out_valid2),
        .out_ready(out_ready2), .y(y2), .busy(busy2), .dbg_state(dbg_state2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- golden model ----------------
    localparam logic [3:0] QT [2][4][16] = '{
        '{'{4'h8,4'h1,4'h7,4'hD,4'h6,4'hF,4'h3,4'h2,4'h0,4'hB,4'h5,4'h9,4'hE,4'hC,4'hA,4'h4},
          '{4'hE,4'hC,4'hB,4'h8,4'h1,4'h2,4'h3,4'h5,4'hF,4'h4,4'hA,4'h6,4'h7,4'h0,4'h9,4'hD},
          '{4'hB,4'hA,4'h5,4'hE,4'h6,4'hD,4'h9,4'h0,4'hC,4'h8,4'hF,4'h3,4'h2,4'h4,4'h7,4'h1},
          '{4'hD,4'h7,4'hF,4'h4,4'h1,4'h2,4'h6,4'hE,4'h9,4'hB,4'h3,4'h0,4'h8,4'h5,4'hC,4'hA}},
        '{'{4'h2,4'h8,4'hB,4'hD,4'hF,4'h7,4'h6,4'hE,4'h3,4'h1,4'h9,4'h4,4'h0,4'hA,4'hC,4'h5},
          '{4'h1,4'hE,4'h2,4'hB,4'h4,4'hC,4'h3,4'h7,4'h6,4'hD,4'hA,4'h5,4'hF,4'h9,4'h0,4'h8},
          '{4'h4,4'hC,4'h7,4'h5,4'h1,4'h6,4'h9,4'hA,4'h0,4'hE,4'hD,4'h8,4'h2,4'hB,4'h3,4'hF},
          '{4'hB,4'h9,4'h5,4'h1,4'hC,4'h3,4'hD,4'hE,4'h6,4'h4,4'h7,4'hF,4'h2,4'h0,4'h8,4'hA}}
    };

    logic [7:0] q0_tab [256];
    logic [7:0] q1_tab [256];

    function automatic logic [7:0] q_calc(input logic [7:0] v, input int w);
        logic [3:0] a, b, ta, tb;
        a  = v[7:4];
        b  = v[3:0];
        ta = a ^ b;
        tb = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
        a  = QT[w][0][ta];
        b  = QT[w][1][tb];
        ta = a ^ b;
        tb = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
        a  = QT[w][2][ta];
        b  = QT[w][3][tb];
        return {b, a};
    endfunction

    function automatic int eff_k(input logic [1:0] kl, input int maxk);
        int k;
        k = (kl == 2'd0) ? 2 : (kl == 2'd1) ? 3 : 4;
        return (k > maxk) ? maxk : k;
    endfunction

    // Standard per-byte h chain (without MDS).
    function automatic logic [31:0] h_model(input int k, input logic [31:0] xx,
                                            input logic [31:0] k0, input logic [31:0] k1,
                                            input logic [31:0] k2, input logic [31:0] k3);
        logic [7:0] b0, b1, b2, b3;
        {b3, b2, b1, b0} = xx;
        if (k == 4) begin
            b0 = q1_tab[b0] ^ k3[7:0];   b1 = q0_tab[b1] ^ k3[15:8];
            b2 = q0_tab[b2] ^ k3[23:16]; b3 = q1_tab[b3] ^ k3[31:24];
        end
        if (k >= 3) begin
            b0 = q1_tab[b0] ^ k2[7:0];   b1 = q1_tab[b1] ^ k2[15:8];
            b2 = q0_tab[b2] ^ k2[23:16]; b3 = q0_tab[b3] ^ k2[31:24];
        end
        b0 = q0_tab[b0] ^ k1[7:0];   b1 = q1_tab[b1] ^ k1[15:8];
        b2 = q0_tab[b2] ^ k1[23:16]; b3 = q1_tab[b3] ^ k1[31:24];
        b0 = q0_tab[b0] ^ k0[7:0];   b1 = q0_tab[b1] ^ k0[15:8];
        b2 = q1_tab[b2] ^ k0[23:16]; b3 = q1_tab[b3] ^ k0[31:24];
        b0 = q1_tab[b0]; b1 = q0_tab[b1]; b2 = q1_tab[b2]; b3 = q0_tab[b3];
        return {b3, b2, b1, b0};
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];
    int          n_sent = 0;
    int          n_results = 0;
    int          last_acc = 0;
    int          hs_cyc = 0;
    int          rdy_mode = 0;   // 0 always ready, 1 random stalls, 2 held low
    logic [31:0] cur_exp = '0;
    bit          ov_prev = 0;
    bit          hs_prev = 0;

    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        if (rst) begin
            ov_prev = 0;
            hs_prev = 0;
        end else begin
            if (hs_prev) begin
                check_eq("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
                check_eq("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
            end
            hs_prev = 0;
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_result", {31'd0, out_valid}, 32'd0);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check_eq("y", y, cur_exp);
                    check_eq("latency", cyc - acc_q.pop_front(), lat_q.pop_front());
                    n_results++;
                end
            end else if (out_valid) begin
                check_eq("y_hold", y, cur_exp);
            end
            if (out_valid && out_ready) begin
                hs_prev = 1;
                hs_cyc  = cyc;
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] kl, input logic [31:0] xx,
                        input logic [31:0] k0, input logic [31:0] k1,
                        input logic [31:0] k2, input logic [31:0] k3, input bit track);
        int waitc;
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        klen = kl; x = xx; l0 = k0; l1 = k1; l2 = k2; l3 = k3;
        waitc = 0;
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            k = eff_k(kl, 4);
            if (track) begin
                exp_q.push_back(h_model(k, xx, k0, k1, k2, k3));
                lat_q.push_back(2 * (k + 1));
                n_sent++;
            end
            @(posedge clk);
            #1;
            last_acc = cyc;
            if (track) acc_q.push_back(cyc);
            in_valid = 1'b0;
            x = $urandom;
            klen = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check_eq("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] rx, r0, r1, r2, r3;
    int          w, stamp;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        klen = 2'd0; x = '0; l0 = '0; l1 = '0; l2 = '0; l3 = '0;
        for (int i = 0; i < 256; i++) begin
            q0_tab[i] = q_calc(8'(i), 0);
            q1_tab[i] = q_calc(8'(i), 1);
        end
        check_eq("q0_of_00", {24'd0, q0_tab[0]}, 32'hA9);
        check_eq("q1_of_00", {24'd0, q1_tab[0]}, 32'h75);
        check_eq("q0_of_01", {24'd0, q0_tab[1]}, 32'h67);
        check_eq("q1_of_01", {24'd0, q1_tab[1]}, 32'hF3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_y", y, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;

        // Reset during RUN: the aborted operation must never produce a result.
        send(2'd2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("midrun_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_y", y, 32'd0);
        check_eq("abort_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Directed vectors.
        send(2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        wait_idle();
        send(2'd1, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 32'h0F1E2D3C, 1'b1);
        wait_idle();
        send(2'd2, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 32'h0F1E2D3C, 1'b1);
        wait_idle();
        send(2'd1, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 32'hA5A55A5A, 1'b1);
        wait_idle();
        send(2'd2, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 32'hA5A55A5A, 1'b1);
        wait_idle();
        // klen=3 must behave like klen=2.
        send(2'd3, 32'hDEADBEEF, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 1'b1);
        wait_idle();
        send(2'd2, 32'hDEADBEEF, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 1'b1);
        wait_idle();

        // Backpressure in DONE with a new request held meanwhile.
        rdy_mode = 2;
        send(2'd0, 32'hCAFEBABE, 32'h01020304, 32'h05060708, 32'h0, 32'h0, 1'b1);
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        check_eq("bp_reach_done", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1; klen = 2'd1; x = 32'h13579BDF;
        l0 = 32'h2468ACE0; l1 = 32'h0; l2 = 32'hFFFFFFFF; l3 = 32'h0;
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        rdy_mode = 0;
        send(2'd1, 32'h13579BDF, 32'h2468ACE0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1);
        check_eq("bp_accept_after_idle", last_acc, hs_cyc + 2);
        wait_idle();

        // MAX_K=2 build: klen=2 is clamped to k=2.
        @(negedge clk);
        klen = 2'd2; x = 32'h01234567; l0 = 32'h89ABCDEF; l1 = 32'hFEDCBA98;
        l2 = 32'h76543210; l3 = 32'h0F1E2D3C;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        stamp = cyc;
        in_valid2 = 1'b0;
        w = 0;
        while (!out_valid2 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check_eq("maxk2_latency", cyc - stamp, 32'd6);
        check_eq("maxk2_y", y2, h_model(2, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
                                        32'h76543210, 32'h0F1E2D3C));

        // Random traffic with random output stalls.
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rx = $urandom; r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            send(2'($urandom_range(0, 3)), rx, r0, r1, r2, r3, 1'b1);
        end
        wait_idle();
        rdy_mode = 0;
        repeat (4) @(negedge clk);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("result_count", n_results, n_sent);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
